vga_scanout: RTL and testbench
==============================

# vga_scanout

Raster timing generator and output stage for the 640x480 VGA display. Scans a 640x480@60 frame at one pixel per `clk`. Drives the 2x-downscaled pixel coordinates (`xvga` 0–319, `yvga` 0–239) that feed the colour-selection stage, and takes back that stage's 3-bit pixel colour after its fixed pipeline latency. Aligns colour, syncs and blanking, then registers them onto the VGA pins.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 33, vertical back porch
- `PIPE_DELAY`, 2, cycles from `xvga`/`yvga` change to matching `color` at input; range 1–4

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `color` in 3: pixel colour {R,G,B} for the coordinates driven `PIPE_DELAY` cycles earlier.
- `xvga` out 9: downscaled column, `hcount[9:1]` when active, else 0.
- `yvga` out 8: downscaled row, `vcount[8:1]` when active, else 0.
- `frame_start` out 1: one-cycle pulse when counters are at (0,0).
- `vga_r`, `vga_g`, `vga_b` out 4 each: colour channels, each `{4{color bit}}`, 0 when blanked.
- `vga_hs`, `vga_vs` out 1: syncs, active low.
- `blank` out 1: high outside the visible area.

## Operation
- **Counters.** `hcount` runs 0..799 (H_TOTAL = 800) and wraps to 0. `vcount` increments when `hcount` wraps, runs 0..524 (V_TOTAL = 525) and wraps to 0.
- **Active area.** `active = hcount < H_ACTIVE && vcount < V_ACTIVE`.
- **Coordinates.** `xvga`/`yvga` are combinational from the registered counters. They are forced to 0 when not active, so `yvga` never exceeds 239 and `xvga` never exceeds 319.
- **Raw syncs.** `hs_raw` is low for `hcount` in [656, 752). `vs_raw` is low for `vcount` in [490, 492).
- **Alignment.** `{active, hs_raw, vs_raw}` pass through a `PIPE_DELAY`-stage shift register, so they line up with the incoming `color`.
- **Output register.** One final register stage captures the aligned syncs, `blank = !active_d`, and `rgb = active_d ? color : 0`.
- **`frame_start`.** Equals `!reset && hcount == 0 && vcount == 0`. It is undelayed and intended for game-logic frame ticks.
- **Reset.** Counters go to 0. Every delay-line stage and output register goes to the inactive value: hs = 1, vs = 1, blank = 1, rgb = 0.
- **Reset mid-frame.** Same as above: the scan restarts at (0,0) on the first cycle after `reset` falls. Outputs stay inactive until the pipeline refills.

## Timing
- **Latency.** Counter state at cycle n appears on the pins at cycle n + PIPE_DELAY + 1.
- **Coordinate timing.** `xvga`/`yvga` have zero latency from the counters.
- **Line and frame.** One line is 800 cycles; one frame is 420000 cycles. `frame_start` period is 420000 cycles.
- **After reset.** On the first cycle after `reset` deasserts, `hcount = vcount = 0` and `frame_start = 1`.
- **Wrap.** At `hcount = 799`, `vcount = 524`, both counters wrap to 0 on the same edge.
- **Colour sampling.** `color` is sampled only at the output register. Its value during blanking is ignored.
- **Reset values.** While `reset` is high: `vga_hs = 1`, `vga_vs = 1`, `blank = 1`, all rgb = 0, `xvga = 0`, `yvga = 0`, `frame_start = 0`.

## Structure
- **Shared package.** `vga_pkg` holds the timing constants H_ACTIVE..V_BP and derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END. It also holds the `{R,G,B}` colour bit-index constants shared with the colour-selection stage.
- **Sub-module.** `pipe_delay` is a parameterised-width, parameterised-depth shift register with synchronous reset to a parameterised init value. It is used once, for `{active, hs, vs}`.
- **Top level.** Counters, decode and the output register live in the top level.

## Test plan
1. **Reset values.** Hold `reset` 5 cycles mid-line. Each cycle: `vga_hs = 1`, `vga_vs = 1`, `blank = 1`, rgb = 0, `xvga = 0`. On release, `frame_start = 1` on the first cycle, then again exactly 420000 cycles later.
2. **Horizontal timing.** After reset, count cycles. `vga_hs` falls 656 + PIPE_DELAY + 1 = 659 cycles after release, stays low 96 cycles, and has an 800-cycle period.
3. **Vertical timing.** `vga_vs` is low for exactly 1600 cycles (2 lines), starting 490×800 + 3 = 392003 cycles after reset release.
4. **Coordinate mapping.** At `hcount` 638/639/640, `xvga` = 319/319/0. At `vcount = 479`, `yvga = 239`. At `vcount = 480`, `yvga = 0` on every cycle.
5. **Colour alignment.** A model drives `color = xvga[2:0]` delayed by PIPE_DELAY. Every visible pin pixel must then satisfy `vga_r == {4{xvga_at_scan[2]}}`, where `xvga_at_scan` is the coordinate driven at scan time. Drive `color = 3'b111` during blanking; rgb must stay 0.
6. **Reset mid-frame.** Pulse `reset` for 1 cycle at `vcount = 200`, `hcount = 300`. The next cycle has counters (0,0) and `frame_start = 1`. `blank` stays 1 for 3 cycles, then visible pixels resume from `xvga = 0`.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: timing constants for the 640x480@60 raster, the colour bit
// positions shared with the colour-selection stage, and the record that
// travels down the sync/blank alignment pipeline.
package vga_pkg;

    // Horizontal timing, in pixel clocks.
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;

    // Vertical timing, in lines.
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Bit positions inside the 3-bit {R,G,B} colour word.
    localparam int unsigned COLOR_R = 2;
    localparam int unsigned COLOR_G = 1;
    localparam int unsigned COLOR_B = 0;

    typedef logic [2:0] color_t;

    // Per-pixel raster state carried alongside the colour pipeline.
    // hs/vs are active low.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_t;

    localparam scan_t SCAN_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/pipe_delay.sv
// pipe_delay: fixed-depth shift register with synchronous reset of every
// stage to INIT.
//   clk_i   : clock
//   reset_i : synchronous active-high reset, loads INIT into all stages
//   d_i     : data in
//   q_o     : data in delayed by DEPTH clocks
module pipe_delay #(
    parameter int unsigned       WIDTH = 1,
    parameter int unsigned       DEPTH = 1,
    parameter logic [WIDTH-1:0]  INIT  = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= INIT;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator and VGA output stage.
//   clk          : pixel clock
//   reset        : synchronous active-high reset
//   color        : {R,G,B} for the coordinates driven PIPE_DELAY clocks earlier
//   xvga, yvga   : half-resolution coordinates, 0 outside the visible area
//   frame_start  : one-clock pulse while the scan is at (0,0)
//   vga_r/g/b    : 4-bit channels, each bit replicated from color, 0 in blanking
//   vga_hs/vs    : active-low syncs
//   blank        : high outside the visible area
// Pin latency from counter state is PIPE_DELAY + 1 clocks.
module vga_scanout #(
    parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP       = vga_pkg::H_FP,
    parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned H_BP       = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP       = vga_pkg::V_FP,
    parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned V_BP       = vga_pkg::V_BP,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] color,
    output logic [8:0] xvga,
    output logic [7:0] yvga,
    output logic       frame_start,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       blank
);

    import vga_pkg::*;

    localparam int unsigned LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(LINE_LEN - 1);
    localparam logic [9:0] V_LAST = 10'(FRAME_LINES - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       active;
    scan_t      scan_raw;
    scan_t      scan_aligned;

    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    color_t     rgb_q, rgb_d;

    // Raster counters: vcount advances on the hcount wrap.
    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // Decode of the current (undelayed) scan position.
    always_comb begin
        active        = (hcount_q < H_VIS) && (vcount_q < V_VIS);
        scan_raw        = SCAN_IDLE;
        scan_raw.active = active;
        scan_raw.hs     = !((hcount_q >= HS_LO) && (hcount_q < HS_HI));
        scan_raw.vs     = !((vcount_q >= VS_LO) && (vcount_q < VS_HI));
    end

    assign xvga        = active ? hcount_q[9:1] : '0;
    assign yvga        = active ? vcount_q[8:1] : '0;
    assign frame_start = !reset && (hcount_q == '0) && (vcount_q == '0);

    // Delay syncs/active so they meet the colour returned by the
    // colour-selection stage for the same pixel.
    pipe_delay #(
        .WIDTH ($bits(scan_t)),
        .DEPTH (PIPE_DELAY),
        .INIT  (SCAN_IDLE)
    ) u_align (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (scan_raw),
        .q_o     (scan_aligned)
    );

    // Output register: colour is only accepted inside the visible area.
    always_comb begin
        hs_d    = scan_aligned.hs;
        vs_d    = scan_aligned.vs;
        blank_d = !scan_aligned.active;
        rgb_d   = scan_aligned.active ? color : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vga_hs = hs_q;
    assign vga_vs = vs_q;
    assign blank  = blank_q;
    assign vga_r  = {4{rgb_q[COLOR_R]}};
    assign vga_g  = {4{rgb_q[COLOR_G]}};
    assign vga_b  = {4{rgb_q[COLOR_B]}};

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: full horizontal timing, shortened vertical timing
// (19 lines per frame) so whole frames fit in a short run.
module tb_vga_scanout;

    localparam int unsigned D   = 2;
    localparam int unsigned HA  = 640;
    localparam int unsigned HFP = 16;
    localparam int unsigned HSY = 96;
    localparam int unsigned HBP = 48;
    localparam int unsigned VA  = 12;
    localparam int unsigned VFP = 2;
    localparam int unsigned VSY = 2;
    localparam int unsigned VBP = 3;

    localparam int HT  = HA + HFP + HSY + HBP;   // 800
    localparam int VT  = VA + VFP + VSY + VBP;   // 19
    localparam int HSS = HA + HFP;               // 656
    localparam int HSE = HSS + HSY;              // 752
    localparam int VSS = VA + VFP;               // 14
    localparam int VSE = VSS + VSY;              // 16

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] color = '0;
    logic [8:0] xvga;
    logic [7:0] yvga;
    logic       frame_start;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, blank;

    vga_scanout #(
        .H_ACTIVE   (HA),
        .H_FP       (HFP),
        .H_SYNC     (HSY),
        .H_BP       (HBP),
        .V_ACTIVE   (VA),
        .V_FP       (VFP),
        .V_SYNC     (VSY),
        .V_BP       (VBP),
        .PIPE_DELAY (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .color       (color),
        .xvga        (xvga),
        .yvga        (yvga),
        .frame_start (frame_start),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .blank       (blank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pin_t;

    localparam pin_t IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, r: 4'h0, g: 4'h0, b: 4'h0};

    typedef struct {
        int unsigned cyc;
        int          x;
        int          y;
        bit          fs;
        bit          hs;
        bit          vs;
        bit          bl;
    } probe_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   hm = 0;
    int   vm = 0;
    int   c  = 0;
    bit   rst_prev = 1'b1;
    pin_t exp_q[$];
    logic [2:0] colh [D+1];

    function automatic bit m_active(int h, int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic pin_t m_pins(int h, int v);
        pin_t p;
        int   x;
        p = IDLE;
        p.hs = !((h >= HSS) && (h < HSE));
        p.vs = !((v >= VSS) && (v < VSE));
        if (m_active(h, v)) begin
            x = h / 2;
            p.blank = 1'b0;
            p.r = {4{x[2]}};
            p.g = {4{x[1]}};
            p.b = {4{x[0]}};
        end
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (c=%0d h=%0d v=%0d): got %0h, want %0h", name, c, hm, vm, act, exp);
        end
    endtask

    // One pixel clock: advance the model, drive inputs, compare everything.
    task automatic step(input logic rst);
        pin_t a, e;
        logic [2:0] cval;
        int ex, ey;
        @(posedge clk);
        if (rst_prev) begin
            hm = 0;
            vm = 0;
            exp_q.delete();
            for (int i = 0; i <= D; i++) exp_q.push_back(IDLE);
        end else begin
            exp_q.push_back(m_pins(hm, vm));
            hm++;
            if (hm == HT) begin
                hm = 0;
                vm++;
                if (vm == VT) vm = 0;
            end
        end
        c = (rst || rst_prev) ? 0 : c + 1;
        #1;
        reset = rst;
        // Colour source: low bits of the scan coordinate, all-ones in blanking.
        cval = m_active(hm, vm) ? 3'(hm / 2) : 3'b111;
        for (int i = D; i > 0; i--) colh[i] = colh[i-1];
        colh[0] = cval;
        color = colh[D];
        #1;
        ex = m_active(hm, vm) ? hm / 2 : 0;
        ey = m_active(hm, vm) ? vm / 2 : 0;
        check("coord", {14'd0, frame_start, yvga, xvga},
              {14'd0, (!rst && hm == 0 && vm == 0), 8'(ey), 9'(ex)});
        a = {vga_hs, vga_vs, blank, vga_r, vga_g, vga_b};
        e = exp_q.pop_front();
        check("pins", 32'(a), 32'(e));
        rst_prev = rst;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        probe_t tbl[$];
        for (int i = 0; i <= D; i++) colh[i] = 3'b111;

        //                 cyc    x    y  fs hs vs bl
        tbl.push_back('{    0,   0,   0, 1, 1, 1, 1});
        tbl.push_back('{    1,   0,   0, 0, 1, 1, 1});
        tbl.push_back('{    3,   1,   0, 0, 1, 1, 0});
        tbl.push_back('{  638, 319,   0, 0, 1, 1, 0});
        tbl.push_back('{  639, 319,   0, 0, 1, 1, 0});
        tbl.push_back('{  640,   0,   0, 0, 1, 1, 0});
        tbl.push_back('{  642,   0,   0, 0, 1, 1, 0});
        tbl.push_back('{  643,   0,   0, 0, 1, 1, 1});
        tbl.push_back('{  658,   0,   0, 0, 1, 1, 1});
        tbl.push_back('{  659,   0,   0, 0, 0, 1, 1});
        tbl.push_back('{  754,   0,   0, 0, 0, 1, 1});
        tbl.push_back('{  755,   0,   0, 0, 1, 1, 1});
        tbl.push_back('{ 1438, 319,   0, 0, 1, 1, 0});
        tbl.push_back('{ 1459,   0,   0, 0, 0, 1, 1});
        tbl.push_back('{ 2410,   5,   1, 0, 1, 1, 0});
        tbl.push_back('{ 8805,   2,   5, 0, 1, 1, 0});
        tbl.push_back('{ 9605,   0,   0, 0, 1, 1, 1});
        tbl.push_back('{11202,   0,   0, 0, 1, 1, 1});
        tbl.push_back('{11203,   0,   0, 0, 1, 0, 1});
        tbl.push_back('{12802,   0,   0, 0, 1, 0, 1});
        tbl.push_back('{12803,   0,   0, 0, 1, 1, 1});
        tbl.push_back('{15199,   0,   0, 0, 1, 1, 1});
        tbl.push_back('{15200,   0,   0, 1, 1, 1, 1});
        tbl.push_back('{15203,   1,   0, 0, 1, 1, 0});

        // Power-on reset, then run into the middle of a line.
        for (int i = 0; i < 4; i++) step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b0);

        // Reset held for 5 clocks mid-line.
        for (int k = 0; k < 5; k++) begin
            step(1'b1);
            if (k >= 1) begin
                check("rst_hs",    32'(vga_hs), 32'd1);
                check("rst_vs",    32'(vga_vs), 32'd1);
                check("rst_blank", 32'(blank), 32'd1);
                check("rst_rgb",   {20'd0, vga_r, vga_g, vga_b}, 32'd0);
                check("rst_xvga",  32'(xvga), 32'd0);
                check("rst_fs",    32'(frame_start), 32'd0);
            end
        end
        step(1'b0);
        check("rel_fs", 32'(frame_start), 32'd1);

        // Timing probes measured from the release cycle above.
        foreach (tbl[i]) begin
            while (c < int'(tbl[i].cyc)) step(1'b0);
            check($sformatf("tbl%0d_x", i),  32'(xvga), 32'(tbl[i].x));
            check($sformatf("tbl%0d_y", i),  32'(yvga), 32'(tbl[i].y));
            check($sformatf("tbl%0d_fs", i), 32'(frame_start), 32'(tbl[i].fs));
            check($sformatf("tbl%0d_hs", i), 32'(vga_hs), 32'(tbl[i].hs));
            check($sformatf("tbl%0d_vs", i), 32'(vga_vs), 32'(tbl[i].vs));
            check($sformatf("tbl%0d_bl", i), 32'(blank), 32'(tbl[i].bl));
        end

        // Single-clock reset at vcount 8, hcount 300.
        for (int k = 0; k < 20000 && !(vm == 8 && hm == 299); k++) step(1'b0);
        step(1'b1);
        check("mid_x_before", 32'(xvga), 32'd150);
        check("mid_fs_before", 32'(frame_start), 32'd0);
        step(1'b0);
        check("mid_x0",  32'(xvga), 32'd0);
        check("mid_y0",  32'(yvga), 32'd0);
        check("mid_fs",  32'(frame_start), 32'd1);
        check("mid_bl0", 32'(blank), 32'd1);
        step(1'b0);
        check("mid_bl1", 32'(blank), 32'd1);
        step(1'b0);
        check("mid_bl2", 32'(blank), 32'd1);
        step(1'b0);
        check("mid_bl3", 32'(blank), 32'd0);
        check("mid_r3",  32'(vga_r), 32'd0);
        for (int i = 0; i < 2000; i++) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
